// File: rtl/lutram_uart_dump.sv
// Walks every bit of a 2**ADDR_W x 1 distributed RAM through its async read port and
// streams the contents out of a UART tx pin as 8N1 bytes, lowest address in bit 0.
module lutram_uart_dump #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // A 1-bit dummy byte index keeps the ADDR_W == 3 (single byte) build legal.
    localparam int BYTE_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'((2 ** ADDR_W) / 8 - 1);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        F_SET,
        F_CAP,
        T_START,
        T_DATA,
        T_STOP,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [15:0]       baud_q, baud_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            shreg_q    <= '0;
            rd_addr_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            shreg_q    <= shreg_d;
            rd_addr_q  <= rd_addr_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // F_SET drives the address, F_CAP samples a cycle later so DPO has fully settled.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        shreg_d    = shreg_q;
        rd_addr_d  = rd_addr_q;
        bit_end    = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = F_SET;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    baud_d     = '0;
                end
            end
            F_SET: begin
                rd_addr_d = ADDR_W'({byte_idx_q, bit_idx_q});
                state_d   = F_CAP;
            end
            F_CAP: begin
                shreg_d[bit_idx_q] = rd_data;
                if (bit_idx_q == 3'd7) begin
                    bit_idx_d = '0;
                    baud_d    = '0;
                    state_d   = T_START;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = F_SET;
                end
            end
            T_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = T_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            T_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = T_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            T_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = FIN;
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        bit_idx_d  = '0;
                        state_d    = F_SET;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered tx lines up with it.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            T_START: tx_d = 1'b0;
            T_DATA:  tx_d = shreg_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) && (state_d != FIN);
        done_d = (state_q == FIN);
    end

    assign rd_addr = rd_addr_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lutram_uart_dump.sv
// Bench for lutram_uart_dump: a 128-bit RAM build at 4 clocks/bit and a single-byte
// build at 2 clocks/bit, checked against hand-computed byte streams and cycle counts.
module tb_lutram_uart_dump;

    localparam int CPB_A    = 4;
    localparam int AW_A     = 7;
    localparam int CPB_B    = 2;
    localparam int AW_B     = 3;
    localparam int PERIOD_A = 16 + 10 * CPB_A;
    localparam int DUMP_A   = 16 * PERIOD_A + 1;
    localparam logic [127:0] INIT_A = 128'hFFEEDDCCBBAA99887766554433221100;

    typedef struct {
        string        name;
        int           wr_cycle;
        int           start_addr;
        logic [127:0] exp_stream;
    } dump_vec_t;

    typedef struct {
        string      name;
        logic [7:0] ram;
        logic [7:0] exp_byte;
    } small_vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_a, start_b;
    logic [AW_A-1:0] rd_addr_a;
    logic            rd_data_a, tx_a, busy_a, done_a;
    logic [AW_B-1:0] rd_addr_b;
    logic            rd_data_b, tx_b, busy_b, done_b;
    logic [127:0]    mem_a;
    logic [7:0]      mem_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] rxq_a[$];
    bit         mon_act = 1'b0;
    int         mon_pos = 0;
    logic [7:0] mon_byte = 8'h00;

    dump_vec_t  dump_vecs[2];
    small_vec_t small_vecs[2];

    assign rd_data_a = mem_a[rd_addr_a];
    assign rd_data_b = mem_b[rd_addr_b];

    always #5 clk = ~clk;

    lutram_uart_dump #(.CLKS_PER_BIT(CPB_A), .ADDR_W(AW_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    lutram_uart_dump #(.CLKS_PER_BIT(CPB_B), .ADDR_W(AW_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // UART receiver: samples the middle of each bit cell, pushes {stop, data}.
    always @(negedge clk) begin
        if (rst) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (tx_a === 1'b0) begin
                mon_act <= 1'b1;
                mon_pos <= 1;
            end
        end else begin
            mon_pos <= mon_pos + 1;
            if ((mon_pos % CPB_A == CPB_A / 2) && (mon_pos / CPB_A >= 1) && (mon_pos / CPB_A <= 8))
                mon_byte[mon_pos / CPB_A - 1] <= tx_a;
            if (mon_pos == 9 * CPB_A + CPB_A / 2) begin
                rxq_a.push_back({tx_a, mon_byte});
                mon_act <= 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents start for one edge; on return the sample point is just after the accept edge.
    task automatic apply_stimulus(input bit use_b);
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    function automatic int exp_rd_addr(input int k, input int start_addr);
        int b;
        int r;
        if (k >= 16 * PERIOD_A) return 127;
        b = k / PERIOD_A;
        r = k % PERIOD_A;
        if (r == 0) return (b == 0) ? start_addr : 8 * b - 1;
        if (r <= 15) return 8 * b + (r - 1) / 2;
        return 8 * b + 7;
    endfunction

    function automatic logic exp_tx_b(input int k, input logic [7:0] pat);
        if (k == 16 || k == 17) return 1'b0;
        if (k >= 18 && k <= 33) return pat[(k - 18) / 2];
        return 1'b1;
    endfunction

    initial begin
        int base;
        int done1, done2, done3, rise1, rise2, rises, dones;
        int kk;
        logic prev_busy;
        logic [8:0] got;

        dump_vecs[0] = '{"plain", -1, 0, 128'hFFEEDDCCBBAA99887766554433221100};
        dump_vecs[1] = '{"wr8", 30, 127, 128'hFFEEDDCCBBAA99887766554433221000};
        small_vecs[0] = '{"b00", 8'h00, 8'h00};
        small_vecs[1] = '{"bA5", 8'hA5, 8'hA5};

        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mem_a = INIT_A;
        mem_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset tx", tx_a, 1'b1);
        check_output("reset busy", busy_a, 1'b0);
        check_output("reset done", done_a, 1'b0);
        check_output("reset rd_addr", rd_addr_a, 0);
        check_output("reset tx_b", tx_b, 1'b1);
        rst = 1'b0;
        tick();

        // Full dumps of the 128-bit RAM, one with a write landing mid-dump.
        for (int v = 0; v < 2; v++) begin
            mem_a = INIT_A;
            base = rxq_a.size();
            apply_stimulus(1'b0);
            for (int k = 0; k <= DUMP_A + 8; k++) begin
                if (k > 0) tick();
                check_output($sformatf("%s busy k=%0d", dump_vecs[v].name, k), busy_a, k < DUMP_A - 1);
                check_output($sformatf("%s done k=%0d", dump_vecs[v].name, k), done_a, k == DUMP_A);
                check_output($sformatf("%s rd_addr k=%0d", dump_vecs[v].name, k), rd_addr_a,
                             exp_rd_addr(k, dump_vecs[v].start_addr));
                if (k == dump_vecs[v].wr_cycle) mem_a[8] = 1'b0;
            end
            check_output($sformatf("%s byte count", dump_vecs[v].name), rxq_a.size() - base, 16);
            for (int i = 0; i < 16 && base + i < rxq_a.size(); i++) begin
                got = rxq_a[base + i];
                check_output($sformatf("%s byte%0d", dump_vecs[v].name, i), got[7:0],
                             dump_vecs[v].exp_stream[8*i +: 8]);
                check_output($sformatf("%s stop%0d", dump_vecs[v].name, i), got[8], 1'b1);
            end
            check_output($sformatf("%s idle tx", dump_vecs[v].name), tx_a, 1'b1);
        end
        mem_a = INIT_A;

        // start held high: back-to-back dumps, re-accept one cycle after done.
        done1 = -1; done2 = -1; done3 = -1; rise1 = -1; rise2 = -1; rises = 0; dones = 0;
        start_a = 1'b1;
        tick();
        prev_busy = busy_a;
        check_output("held first accept", busy_a, 1'b1);
        kk = 0;
        for (int k = 1; k < 2000; k++) begin
            tick();
            kk = k;
            if (done_a) begin
                dones++;
                if (done1 < 0) done1 = k; else if (done2 < 0) done2 = k;
                check_output($sformatf("held busy at done k=%0d", k), busy_a, 1'b0);
            end
            if (busy_a && !prev_busy) begin
                rises++;
                if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
            end
            prev_busy = busy_a;
        end
        start_a = 1'b0;
        check_output("held done1 cycle", done1, DUMP_A);
        check_output("held accept2 cycle", rise1, DUMP_A + 1);
        check_output("held done2 cycle", done2, 2 * DUMP_A + 1);
        check_output("held accept3 cycle", rise2, 2 * DUMP_A + 2);
        check_output("held accept count", rises, 2);
        check_output("held done count", dones, 2);
        for (int j = 0; j < 1500; j++) begin
            tick();
            kk++;
            if (done_a) begin
                done3 = kk;
                break;
            end
        end
        check_output("held done3 cycle", done3, 3 * DUMP_A + 2);
        tick();
        check_output("held final busy", busy_a, 1'b0);

        // Reset during byte 5 (0x55) data bit 3, which is a 0 on the wire.
        apply_stimulus(1'b0);
        for (int k = 1; k <= 5 * PERIOD_A + 16 + CPB_A + 3 * CPB_A + 1; k++) tick();
        check_output("pre-reset tx", tx_a, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_output("async reset tx", tx_a, 1'b1);
        check_output("async reset busy", busy_a, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check_output($sformatf("reset hold done %0d", j), done_a, 1'b0);
        end
        rst = 1'b0;
        check_output("post-reset rd_addr", rd_addr_a, 0);
        tick();
        check_output("post-reset done", done_a, 1'b0);
        base = rxq_a.size();
        apply_stimulus(1'b0);
        for (int k = 1; k <= 2 * PERIOD_A + 4; k++) tick();
        check_output("restart byte count", rxq_a.size() - base, 2);
        for (int i = 0; i < 2 && base + i < rxq_a.size(); i++) begin
            got = rxq_a[base + i];
            check_output($sformatf("restart byte%0d", i), got[7:0], INIT_A[8*i +: 8]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Single-byte build: whole dump fits in one frame.
        for (int v = 0; v < 2; v++) begin
            mem_b = small_vecs[v].ram;
            check_output($sformatf("%s idle before", small_vecs[v].name), tx_b, 1'b1);
            apply_stimulus(1'b1);
            for (int k = 0; k <= 45; k++) begin
                if (k > 0) tick();
                check_output($sformatf("%s tx k=%0d", small_vecs[v].name, k), tx_b,
                             exp_tx_b(k, small_vecs[v].exp_byte));
                check_output($sformatf("%s done k=%0d", small_vecs[v].name, k), done_b, k == 37);
                check_output($sformatf("%s busy k=%0d", small_vecs[v].name, k), busy_b, k < 36);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
